// File: rtl/mux_rr_nch.sv
// N-channel registered multiplexer with per-channel valid qualifiers.
// Selector mode or fair round-robin arbitration, plus saturating drop accounting.
module mux_rr_nch #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            selector,
  input  logic [CHANNELS*WIDTH-1:0]   dataIn,
  input  logic [CHANNELS-1:0]         validIN,
  output logic [WIDTH-1:0]            dataOut,
  output logic                        validOUT,
  output logic [SEL_W-1:0]            grant,
  output logic [CNT_W-1:0]            drop_count
);

  logic [SEL_W-1:0]    last;
  logic [SEL_W-1:0]    cand;
  logic                hit;
  logic [CHANNELS-1:0] served;
  logic [WIDTH-1:0]    data_sel;
  logic                drop_inc;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    hit      = 1'b0;
    cand     = '0;
    served   = '0;
    data_sel = '0;

    if (!mode) begin
      // Comparing against each legal index keeps out-of-range selectors a miss.
      for (int k = 0; k < CHANNELS; k++) begin
        if (selector == SEL_W'(k) && validIN[k]) begin
          hit  = 1'b1;
          cand = SEL_W'(k);
        end
      end
    end else begin
      // Search starts just past the last RR grant and wraps modulo CHANNELS.
      for (int off = 1; off <= CHANNELS; off++) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (!hit && validIN[k] && k == (int'(last) + off) % CHANNELS) begin
            hit  = 1'b1;
            cand = SEL_W'(k);
          end
        end
      end
    end

    for (int k = 0; k < CHANNELS; k++) begin
      if (hit && cand == SEL_W'(k)) begin
        served[k] = 1'b1;
        data_sel  = dataIn[k*WIDTH +: WIDTH];
      end
    end
  end

  assign drop_inc = |(validIN & ~served);

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataOut    <= '0;
      validOUT   <= 1'b0;
      grant      <= '0;
      drop_count <= '0;
      last       <= SEL_W'(CHANNELS - 1);
    end else begin
      validOUT <= hit;
      if (hit) begin
        dataOut <= data_sel;
        grant   <= cand;
        if (mode) last <= cand;
      end
      if (drop_inc && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_rr_nch.sv
// Self-checking bench for mux_rr_nch: directed scenarios plus random traffic,
// a queue-based scoreboard and a behavioural reference model.
module tb_mux_rr_nch;

  localparam int W  = 2;
  localparam int CH = 4;
  localparam int SW = 2;
  localparam int CW = 8;

  typedef struct {
    logic [W-1:0]  data;
    logic          valid;
    logic [SW-1:0] grant;
    logic [CW-1:0] drop;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            mode;
  logic [SW-1:0]   selector;
  logic [CH*W-1:0] dataIn;
  logic [CH-1:0]   validIN;
  logic [W-1:0]    dataOut;
  logic            validOUT;
  logic [SW-1:0]   grant;
  logic [CW-1:0]   drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  // Reference model state
  int m_last;
  int m_data;
  int m_grant;
  int m_drop;

  mux_rr_nch #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .selector(selector),
    .dataIn(dataIn), .validIN(validIN), .dataOut(dataOut),
    .validOUT(validOUT), .grant(grant), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = CH - 1;
    m_data  = 0;
    m_grant = 0;
    m_drop  = 0;
  endtask

  // Applies inputs now and pushes the response expected after the next edge.
  task automatic apply(input logic m, input int sel, input logic [CH*W-1:0] d,
                       input logic [CH-1:0] v);
    bit   hit = 0;
    int   c = 0;
    int   unserved;
    exp_t e;
    mode = m; selector = SW'(sel); dataIn = d; validIN = v;
    if (!m) begin
      c   = sel;
      hit = (sel < CH) && v[sel];
    end else begin
      for (int off = 1; off <= CH; off++) begin
        int k = (m_last + off) % CH;
        if (!hit && v[k]) begin hit = 1; c = k; end
      end
    end
    unserved = $countones(v) - (hit ? 1 : 0);
    if (hit) begin
      m_data  = int'(d[c*W +: W]);
      m_grant = c;
      if (m) m_last = c;
    end
    if (unserved > 0 && m_drop < (1 << CW) - 1) m_drop++;
    e.data = W'(m_data); e.valid = hit; e.grant = SW'(m_grant); e.drop = CW'(m_drop);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic m, input int sel, input logic [CH*W-1:0] d,
                       input logic [CH-1:0] v);
    @(negedge clk);
    apply(m, sel, d, v);
  endtask

  // Monitor: compares each registered response just after the active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dataOut",    32'(dataOut),    32'(e.data));
      check("validOUT",   32'(validOUT),   32'(e.valid));
      check("grant",      32'(grant),      32'(e.grant));
      check("drop_count", 32'(drop_count), 32'(e.drop));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; mode = 1'b0; selector = '0; dataIn = '0; validIN = '0;
    model_reset();

    // Held in reset with random inputs: outputs must stay cleared.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mode = 1'($urandom); selector = SW'($urandom); dataIn = 8'($urandom); validIN = 4'($urandom);
      @(posedge clk); #1;
      check("rst_dataOut",  32'(dataOut),    0);
      check("rst_validOUT", 32'(validOUT),   0);
      check("rst_grant",    32'(grant),      0);
      check("rst_drop",     32'(drop_count), 0);
    end

    // Selector mode: pick channel 2, then lose its valid.
    @(negedge clk);
    reset = 1'b1;
    apply(1'b0, 2, 8'b11_10_01_00, 4'b1111);
    drive(1'b0, 2, 8'b11_10_01_00, 4'b1011);

    // Round-robin fairness with all channels valid.
    for (int i = 0; i < 8; i++) drive(1'b1, 0, 8'($urandom), 4'b1111);

    // Skip and wrap.
    drive(1'b1, 0, 8'($urandom), 4'b0100);
    drive(1'b1, 0, 8'($urandom), 4'b0101);

    // Mode switch: RR grant of 1, selector 3 twice, back to RR.
    drive(1'b1, 0, 8'($urandom), 4'b0010);
    drive(1'b0, 3, 8'($urandom), 4'b1111);
    drive(1'b0, 3, 8'($urandom), 4'b1111);
    drive(1'b1, 0, 8'($urandom), 4'b1111);

    // Random traffic.
    for (int i = 0; i < 200; i++)
      drive(1'($urandom), int'($urandom_range(0, CH - 1)), 8'($urandom), 4'($urandom));

    // Saturation.
    for (int i = 0; i < 300; i++) drive(1'b1, 0, 8'($urandom), 4'b1111);
    @(posedge clk); #2;
    check("sat_drop", 32'(drop_count), 255);

    // Mid-stream asynchronous reset, away from any edge.
    #1;
    reset = 1'b0;
    #1;
    check("async_dataOut",  32'(dataOut),    0);
    check("async_validOUT", 32'(validOUT),   0);
    check("async_grant",    32'(grant),      0);
    check("async_drop",     32'(drop_count), 0);
    model_reset();

    // First edge after release loads data; RR restarts at channel 0.
    @(negedge clk);
    reset = 1'b1;
    apply(1'b1, 0, 8'b01_10_11_01, 4'b1111);
    for (int i = 0; i < 20; i++)
      drive(1'($urandom), int'($urandom_range(0, CH - 1)), 8'($urandom), 4'($urandom));

    @(posedge clk); #2;
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
